// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, parity modes and baud-rate helper
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} rx_state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop line synchroniser with a three-sample majority window
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_serial,
  output logic rxs,
  output logic rxs_prev,
  output logic maj
);
  logic       meta;
  logic [1:0] hist;
  // synchroniser and sample history shift together; everything idles high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {meta, rxs, hist} <= '1;
    else {meta, rxs, hist} <= {rx_serial, meta, hist[0], rxs};
  assign rxs_prev = hist[0];
  assign maj = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with majority sampling, error detection and a one-word buffer
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 49_500_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det
);
  localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF = CPB >> 1;
  localparam int CW   = $clog2(CPB);
  localparam int IW   = $clog2(DATA_BITS);
  localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);

  if (CPB < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > PAR_ODD ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
    $error("uart_rx_param: illegal configuration");
  end

  rx_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [IW-1:0] bit_idx;
  logic [DATA_BITS-1:0] data;
  logic par_bit, stop_idx, ferr;
  logic rxs, rxs_prev, maj;
  logic bit_end, last_stop, fe_all, zero, good, load, perr;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_serial(rx_serial),
    .rxs      (rxs),
    .rxs_prev (rxs_prev),
    .maj      (maj)
  );

  // frame decode strobes and next state; a frame ends at the last stop-bit sample
  always_comb begin
    bit_end   = cnt == C_LAST;
    last_stop = state == S_STOP && bit_end && stop_idx == S_LAST;
    fe_all    = ferr | ~maj;
    zero      = data == '0 && (PARITY == PAR_NONE || !par_bit);
    good      = last_stop && !fe_all;
    load      = good && (!rx_valid || rx_ready);
    perr      = PARITY == PAR_EVEN ? ^{data, par_bit} : PARITY == PAR_ODD ? ~^{data, par_bit} : 1'b0;
    state_n   = state;
    case (state)
      S_IDLE:   state_n = (rxs_prev && !rxs) ? S_START : S_IDLE;
      S_START:  state_n = cnt != C_HALF ? S_START : maj ? S_IDLE : S_DATA;
      S_DATA:   state_n = !(bit_end && bit_idx == I_LAST) ? S_DATA : PARITY != PAR_NONE ? S_PARITY : S_STOP;
      S_PARITY: state_n = bit_end ? S_STOP : S_PARITY;
      S_STOP:   state_n = !last_stop ? S_STOP : (fe_all && zero) ? S_BREAK : S_IDLE;
      S_BREAK:  state_n = rxs ? S_IDLE : S_BREAK;
      default:  state_n = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;

  // bit timing, word assembly, output buffer and one-clock status pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt        <= '0;
      bit_idx    <= '0;
      data       <= '0;
      par_bit    <= 1'b0;
      stop_idx   <= 1'b0;
      ferr       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      cnt      <= (state_n != state || state == S_IDLE || bit_end) ? '0 : cnt + 1'b1;
      bit_idx  <= state != S_DATA ? '0 : bit_end ? bit_idx + 1'b1 : bit_idx;
      if (state == S_DATA && bit_end) data[bit_idx] <= maj;
      if (state == S_PARITY && bit_end) par_bit <= maj;
      stop_idx <= state != S_STOP ? 1'b0 : stop_idx ^ bit_end;
      ferr     <= state != S_STOP ? 1'b0 : ferr | (bit_end & ~maj);
      rx_valid <= load | (rx_valid & ~rx_ready);
      if (load) begin
        rx_data    <= data;
        parity_err <= perr;
      end
      frame_err <= last_stop & fe_all & ~zero;
      overrun   <= good & rx_valid & ~rx_ready;
      break_det <= last_stop & fe_all & zero;
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed checks of the parametrised UART receiver in 8N1, 8E1 and 9O2
module tb_uart_rx_param;
  import uart_pkg::*;

  logic clk, rst_n, rx_ready;
  logic [2:0] ser;
  logic [7:0] d0, d1;
  logic [8:0] d2;
  logic [2:0] v, pe, fe, ov, bk;

  int n_chk = 0, n_pass = 0;
  int nv[3], nf[3], no[3], nb[3];
  int bv[3], bf[3], bo[3], bb[3];
  logic [8:0] ld[3];
  logic lpe[3];
  logic v0_q = 1'b0;
  time tv0, t0;

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .rx_serial(ser[0]), .rx_data(d0), .rx_valid(v[0]), .rx_ready(rx_ready),
    .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .break_det(bk[0]));
  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rx_serial(ser[1]), .rx_data(d1), .rx_valid(v[1]), .rx_ready(rx_ready),
    .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .break_det(bk[1]));
  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(9), .PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .rx_serial(ser[2]), .rx_data(d2), .rx_valid(v[2]), .rx_ready(rx_ready),
    .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .break_det(bk[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // event counters and last accepted word per receiver, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (v[i]) nv[i]++;
      if (fe[i]) nf[i]++;
      if (ov[i]) no[i]++;
      if (bk[i]) nb[i]++;
      if (v[i]) lpe[i] = pe[i];
    end
    if (v[0]) ld[0] = {1'b0, d0};
    if (v[1]) ld[1] = {1'b0, d1};
    if (v[2]) ld[2] = d2;
    if (v[0] && !v0_q) tv0 = $time;
    v0_q = v[0];
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int sel, input logic b);
    ser[sel] = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send(input int sel, input int nd, input logic [8:0] d, input int par, input int ns, input logic sv);
    drive(sel, 1'b0);
    for (int i = 0; i < nd; i++) drive(sel, d[i]);
    if (par >= 0) drive(sel, par[0]);
    for (int i = 0; i < ns; i++) drive(sel, sv);
  endtask

  task automatic snap();
    bv = nv; bf = nf; bo = no; bb = nb;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      nv[i] = 0; nf[i] = 0; no[i] = 0; nb[i] = 0; ld[i] = '0; lpe[i] = 1'b0;
    end
    rst_n = 1'b0;
    ser = '1;
    rx_ready = 1'b1;
    idle(2);
    check("rst_data", d0, 0);
    check("rst_valid", v[0], 0);
    check("rst_perr", pe[0], 0);
    check("rst_ferr", fe[0], 0);
    check("rst_ovr", ov[0], 0);
    check("rst_brk", bk[0], 0);
    rst_n = 1'b1;
    idle(4);

    // 8N1 0xA5, ready high
    snap();
    t0 = $time;
    send(0, 8, 9'h0A5, -1, 1, 1'b1);
    idle(32);
    check("a5_nvalid", nv[0] - bv[0], 1);
    check("a5_data", ld[0], 9'h0A5);
    check("a5_perr", lpe[0], 0);
    check("a5_ferr", nf[0] - bf[0], 0);
    check("a5_ovr", no[0] - bo[0], 0);
    check("a5_latency", int'((tv0 - t0) / 10), 155);

    // 8E1 and 9O2 parity
    snap();
    send(1, 8, 9'h037, 0, 1, 1'b1);
    idle(32);
    check("e_bad_nvalid", nv[1] - bv[1], 1);
    check("e_bad_data", ld[1], 9'h037);
    check("e_bad_perr", lpe[1], 1);
    snap();
    send(1, 8, 9'h037, 1, 1, 1'b1);
    idle(32);
    check("e_ok_nvalid", nv[1] - bv[1], 1);
    check("e_ok_data", ld[1], 9'h037);
    check("e_ok_perr", lpe[1], 0);
    snap();
    send(2, 9, 9'h1FF, 0, 2, 1'b1);
    idle(32);
    check("o_ok_nvalid", nv[2] - bv[2], 1);
    check("o_ok_data", ld[2], 9'h1FF);
    check("o_ok_perr", lpe[2], 0);
    snap();
    send(2, 9, 9'h1FF, 1, 2, 1'b1);
    idle(32);
    check("o_bad_nvalid", nv[2] - bv[2], 1);
    check("o_bad_data", ld[2], 9'h1FF);
    check("o_bad_perr", lpe[2], 1);

    // start glitch of 5 clocks
    snap();
    ser[0] = 1'b0;
    idle(5);
    ser[0] = 1'b1;
    check("glitch_start", int'(u0.state), int'(S_START));
    idle(6);
    check("glitch_idle", int'(u0.state), int'(S_IDLE));
    idle(32);
    check("glitch_nvalid", nv[0] - bv[0], 0);
    check("glitch_ferr", nf[0] - bf[0], 0);
    check("glitch_brk", nb[0] - bb[0], 0);

    // framing error, break, recovery
    snap();
    send(0, 8, 9'h055, -1, 1, 1'b0);
    ser[0] = 1'b1;
    idle(32);
    check("fe_pulse", nf[0] - bf[0], 1);
    check("fe_nvalid", nv[0] - bv[0], 0);
    snap();
    ser[0] = 1'b0;
    idle(12 * 16);
    ser[0] = 1'b1;
    idle(48);
    check("brk_pulse", nb[0] - bb[0], 1);
    check("brk_ferr", nf[0] - bf[0], 0);
    check("brk_nvalid", nv[0] - bv[0], 0);
    snap();
    send(0, 8, 9'h03C, -1, 1, 1'b1);
    idle(32);
    check("after_brk_nvalid", nv[0] - bv[0], 1);
    check("after_brk_data", ld[0], 9'h03C);

    // overrun with ready low
    rx_ready = 1'b0;
    snap();
    send(0, 8, 9'h011, -1, 1, 1'b1);
    send(0, 8, 9'h022, -1, 1, 1'b1);
    idle(32);
    check("ovr_valid", v[0], 1);
    check("ovr_keep_data", d0, 8'h11);
    check("ovr_pulse", no[0] - bo[0], 1);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    check("ovr_drained", v[0], 0);

    // consume on the same edge a new word loads
    send(0, 8, 9'h011, -1, 1, 1'b1);
    check("same_first", d0, 8'h11);
    snap();
    fork
      send(0, 8, 9'h022, -1, 1, 1'b1);
      begin
        idle(154);
        check("same_before", d0, 8'h11);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        check("same_valid", v[0], 1);
        check("same_data", d0, 8'h22);
      end
    join
    idle(32);
    check("same_no_ovr", no[0] - bo[0], 0);
    check("same_hold", d0, 8'h22);
    rx_ready = 1'b1;
    idle(2);

    // asynchronous reset mid-data-bit
    fork
      send(0, 8, 9'h0C3, -1, 1, 1'b1);
      begin
        idle(50);
        rst_n = 1'b0;
        #1;
        check("arst_data", d0, 0);
        check("arst_valid", v[0], 0);
        check("arst_state", int'(u0.state), int'(S_IDLE));
      end
    join
    idle(16);
    rst_n = 1'b1;
    idle(16);
    snap();
    send(0, 8, 9'h0C3, -1, 1, 1'b1);
    idle(32);
    check("c3_nvalid", nv[0] - bv[0], 1);
    check("c3_data", ld[0], 9'h0C3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
